// File: rtl/fma_operand_scheduler.sv
// Operand scheduler: round-robin arbitration of operand writes into per-FMA a/b/c
// slots, then one valid/ready batch issue to the FMA array once every slot is full.
module fma_operand_scheduler #(
    parameter int unsigned FMA_COUNT = 2,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned REQ_COUNT = 4,
    parameter int unsigned IDX_W     = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [REQ_COUNT-1:0]   req_valid_in,
    input  logic [IDX_W-1:0]       req_fma_idx_in [REQ_COUNT],
    input  logic [1:0]             req_slot_in    [REQ_COUNT],
    input  logic [WIDTH-1:0]       req_data_in    [REQ_COUNT],
    output logic [REQ_COUNT-1:0]   req_ready_out,
    output logic [3*WIDTH-1:0]     fma_out        [FMA_COUNT],
    output logic [2:0]             fma_out_valid  [FMA_COUNT],
    input  logic                   fma_ready_in,
    output logic [15:0]            issue_count_out,
    output logic [15:0]            drop_count_out
);

    localparam int unsigned PTR_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int unsigned NSLOT = 3 * FMA_COUNT;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                 state_q;
    logic [NSLOT-1:0]       fill_q;
    logic [PTR_W-1:0]       ptr_q;
    logic                   valid_q;
    logic [3*WIDTH-1:0]     opnd_q [FMA_COUNT];

    logic [REQ_COUNT-1:0]   legal;
    logic [REQ_COUNT-1:0]   eligible;
    logic [NSLOT-1:0]       slot_mask [REQ_COUNT];
    logic                   gnt_found;
    logic [PTR_W-1:0]       gnt_k;
    logic [PTR_W-1:0]       cand;
    logic [NSLOT-1:0]       fill_nxt;
    logic [IDX_W-1:0]       gnt_fma;
    logic [1:0]             gnt_slot;
    logic [WIDTH-1:0]       gnt_data;
    logic                   gnt_legal;

    // Decode each request: illegal ones are always eligible so they can be drained
    always_comb begin
        legal    = '0;
        eligible = '0;
        for (int unsigned k = 0; k < REQ_COUNT; k++) begin
            legal[k]     = (32'(req_fma_idx_in[k]) < FMA_COUNT) && (req_slot_in[k] != 2'd3);
            slot_mask[k] = legal[k]
                ? (NSLOT'(1) << (32'(req_fma_idx_in[k]) * 32'd3 + 32'(req_slot_in[k])))
                : '0;
            eligible[k]  = req_valid_in[k] && (!legal[k] || ((fill_q & slot_mask[k]) == '0));
        end
    end

    // Round-robin pick: first eligible requester at or after the pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_k     = '0;
        cand      = '0;
        for (int unsigned o = 0; o < REQ_COUNT; o++) begin
            cand = PTR_W'((32'(ptr_q) + o) % REQ_COUNT);
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_k     = cand;
            end
        end
    end

    assign gnt_fma   = req_fma_idx_in[gnt_k];
    assign gnt_slot  = req_slot_in[gnt_k];
    assign gnt_data  = req_data_in[gnt_k];
    assign gnt_legal = legal[gnt_k];
    assign fill_nxt  = fill_q | slot_mask[gnt_k];

    always_comb begin
        req_ready_out = '0;
        if (rst_in && (state_q == S_FILL) && gnt_found) begin
            req_ready_out = REQ_COUNT'(1) << gnt_k;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q         <= S_FILL;
            fill_q          <= '0;
            ptr_q           <= '0;
            valid_q         <= 1'b0;
            issue_count_out <= '0;
            drop_count_out  <= '0;
            for (int unsigned f = 0; f < FMA_COUNT; f++) begin
                opnd_q[f] <= '0;
            end
        end else begin
            case (state_q)
                S_FILL: begin
                    if (gnt_found) begin
                        ptr_q <= PTR_W'((32'(gnt_k) + 32'd1) % REQ_COUNT);
                        if (gnt_legal) begin
                            case (gnt_slot)
                                2'd0:    opnd_q[gnt_fma][WIDTH-1:0]         <= gnt_data;
                                2'd1:    opnd_q[gnt_fma][2*WIDTH-1:WIDTH]   <= gnt_data;
                                2'd2:    opnd_q[gnt_fma][3*WIDTH-1:2*WIDTH] <= gnt_data;
                                default: ;
                            endcase
                            fill_q <= fill_nxt;
                            if (&fill_nxt) begin
                                state_q <= S_ISSUE;
                                valid_q <= 1'b1;
                            end
                        end else begin
                            drop_count_out <= drop_count_out + 16'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    // Operands stay stale after the clear; they are only meaningful while valid
                    if (fma_ready_in) begin
                        fill_q          <= '0;
                        issue_count_out <= issue_count_out + 16'd1;
                        state_q         <= S_FILL;
                        valid_q         <= 1'b0;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    for (genvar f = 0; f < FMA_COUNT; f++) begin : g_out
        assign fma_out[f]       = opnd_q[f];
        assign fma_out_valid[f] = {3{valid_q}};
    end

endmodule

// File: doc/fma_operand_scheduler.md
Name: fma_operand_scheduler

Overview:
- Arbitrates operand writes from REQ_COUNT requesters (cache read ports, broadcast unit) into a per-FMA operand scoreboard of a/b/c slots.
- Once every slot of every FMA is filled, issues one batch to the FMA array with a valid/ready handshake, then clears the scoreboard.
- Sits between the data cache read path and the FMA units.
- Replaces ad-hoc fill tracking with round-robin fairness and back-pressure on occupied slots.

Parameters:
- FMA_COUNT, 2, number of FMA units served.
- WIDTH, 16, operand width in bits.
- REQ_COUNT, 4, number of operand requesters.
- IDX_W, max(1, $clog2(FMA_COUNT)), width of the FMA index field.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-low reset.
- req_valid_in  input  [REQ_COUNT-1:0]  per-requester write request.
- req_fma_idx_in  input  [IDX_W-1:0] x REQ_COUNT (unpacked)  target FMA.
- req_slot_in  input  [1:0] x REQ_COUNT  slot select: 0=a [15:0], 1=b [31:16], 2=c [47:32] (WIDTH=16 shown); 3=illegal.
- req_data_in  input  [WIDTH-1:0] x REQ_COUNT  operand value.
- req_ready_out  output  [REQ_COUNT-1:0]  grant, one-hot or zero, combinational.
- fma_out  output  [3*WIDTH-1:0] x FMA_COUNT  packed {c,b,a} operands.
- fma_out_valid  output  [2:0] x FMA_COUNT  3'b111 while a batch is offered, else 3'b000.
- fma_ready_in  input  1  FMA array accepts the batch.
- issue_count_out  output  [15:0]  batches issued; wraps 16'hFFFF -> 0.
- drop_count_out  output  [15:0]  illegal requests discarded; wraps.

Behaviour:
- Reset (rst_in==0 at a clock edge):
  - state=FILL, all fill bits=0, operand regs=0, RR pointer=0, counters=0.
  - fma_out_valid=0, fma_out=0.
  - req_ready_out=0 in every cycle rst_in is low.
  - Reset mid-batch discards all partial and offered operands.
- State FILL, per cycle:
  - A requester k is eligible if req_valid_in[k]=1 and either:
    - the request is illegal (fma_idx>=FMA_COUNT or slot==3), or
    - the target fill bit is 0.
  - Grant the first eligible k scanning ptr, ptr+1, ... mod REQ_COUNT; req_ready_out[k]=1.
  - Transfer occurs on valid&ready in that cycle.
  - On a legal transfer: write the operand, set its fill bit.
  - On an illegal transfer: discard the data, increment drop_count_out.
  - After any grant: ptr <= (k+1) mod REQ_COUNT. With no grant, ptr holds.
  - Requests to an already-filled slot are stalled (ready=0) and do not block other requesters.
  - Requests must hold valid and payload until granted.
- FILL -> ISSUE: on the edge where the last fill bit is set.
  - fma_out_valid=3'b111 for all FMAs from the next cycle.
  - Latency from the final write to valid is 1 cycle.
- State ISSUE:
  - req_ready_out=0.
  - fma_out and fma_out_valid stable until the cycle fma_ready_in=1.
  - On that edge: clear all fill bits, increment issue_count_out, state=FILL, fma_out_valid=0 next cycle.
  - Grants resume in the cycle after the handshake.
  - Operand registers keep stale values after the clear; fma_out is don't-care while valid=0.
- fma_ready_in is ignored in FILL.
- Two requesters targeting the same slot in one cycle: only the RR winner writes; the loser is stalled and is not granted until after the next issue.
- REQ_COUNT=1: the arbiter degenerates to pass-through with the same rules.

Test Plan:
- Single-requester fill: req 0 writes all 6 slots (FMA0 a=16'h3C00, b=16'h4000, c=16'h4200; FMA1 a=1, b=2, c=3), one per cycle, fma_ready_in=1 → fma_out_valid=3'b111 one cycle after the 6th grant; fma_out[0]=48'h4200_4000_3C00, fma_out[1]=48'h0003_0002_0001; issue_count_out=1; valid drops the next cycle.
- Round-robin fairness: all 4 requesters valid to distinct empty slots from ptr=0 → grants in order 0,1,2,3 on consecutive cycles, exactly one grant per cycle.
- Slot conflict: req 0 and req 1 both target FMA0 slot a with 16'hAAAA / 16'hBBBB → req 0 granted, FMA0.a=16'hAAAA; req 1 stalled until the issue handshake, then granted in the first FILL cycle; the next batch has FMA0.a=16'hBBBB.
- Back-pressure: scoreboard full, fma_ready_in=0 for 5 cycles → fma_out and valid held constant and req_ready_out=0 throughout; ready=1 on cycle 6 → issue_count_out increments once.
- Illegal request: slot=3, or fma_idx=1 with FMA_COUNT=1 → granted, no fill bit changes, drop_count_out increments by 1.
- Reset mid-operation: rst_in=0 for 1 cycle after 3 slots are filled, or during ISSUE → valid=0, counters=0, next batch requires all 6 writes again; ptr restarts at 0.
